// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared constants and boot program image for instr_mem
package instr_mem_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT    = 32'h0000_0013;
  localparam int          DEPTH_WORDS_DEFAULT = 64;

  function automatic logic [31:0] image_word(input int unsigned idx,
                                             input logic [31:0] nop);
    case (idx)
      0:       return 32'h0020_81B3;
      1:       return 32'h4011_8233;
      2:       return 32'h0022_72B3;
      3:       return 32'h0032_E333;
      default: return nop;
    endcase
  endfunction

  // Little-endian: byte 0 of a word is its least significant byte.
  function automatic logic [7:0] image_byte(input int unsigned byte_idx,
                                            input logic [31:0] nop);
    logic [31:0] w;
    w = image_word(byte_idx >> 2, nop);
    return w[8*(byte_idx % 4) +: 8];
  endfunction

endpackage

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - read-only byte-addressed instruction memory, one-cycle fetch
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC,
  output logic [31:0] INST_CODE,
  output logic        ADDR_ERR
);

  localparam int BYTES = 4 * DEPTH_WORDS;
  localparam int AW    = $clog2(BYTES);

  logic [7:0]    mem [BYTES];
  logic          fetch_err;
  logic [31:0]   fetch_word;
  logic [AW-3:0] word_sel;

  // Full 32-bit compare so large PCs never alias back into the array.
  always_comb begin
    fetch_err  = (PC[1:0] != 2'b00) || (PC >= 32'(BYTES));
    word_sel   = PC[AW-1:2];
    fetch_word = NOP_WORD;
    if (!fetch_err) begin
      fetch_word = {mem[{word_sel, 2'b11}], mem[{word_sel, 2'b10}],
                    mem[{word_sel, 2'b01}], mem[{word_sel, 2'b00}]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < BYTES; i++) begin
        mem[i] <= image_byte(i, NOP_WORD);
      end
      INST_CODE <= NOP_WORD;
      ADDR_ERR  <= 1'b0;
    end else begin
      INST_CODE <= fetch_word;
      ADDR_ERR  <= fetch_err;
    end
  end

endmodule

// File: tb/tb_instr_mem.sv
// tb/tb_instr_mem.sv - scoreboard testbench for instr_mem
module tb_instr_mem;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    string       name;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK;
  logic        RESET;
  logic [31:0] PC;
  logic [31:0] INST_CODE;
  logic        ADDR_ERR;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  instr_mem dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .PC       (PC),
    .INST_CODE(INST_CODE),
    .ADDR_ERR (ADDR_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic model_err(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc >= 32'd256);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] pc);
    if (model_err(pc)) return NOP;
    case (pc)
      32'd0:   return 32'h002081B3;
      32'd4:   return 32'h40118233;
      32'd8:   return 32'h002272B3;
      32'd12:  return 32'h0032E333;
      default: return NOP;
    endcase
  endfunction

  // Drive one edge and push what the outputs must show after it.
  task automatic drive(input logic [31:0] pc, input logic rst, input string name);
    exp_t e;
    PC    = pc;
    RESET = rst;
    e.inst = rst ? NOP : model_word(pc);
    e.err  = rst ? 1'b0 : model_err(pc);
    e.name = name;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] pcs [4] = '{32'd0, 32'd0, 32'd2, 32'h0000_1000};
    foreach (pcs[i]) begin
      drive(pcs[i], 1'b1, "reset");
      e = sb.pop_front();
      checks++;
      if (INST_CODE !== e.inst) begin
        failures++;
        $display("FAIL %s[%0d] inst got %h want %h", e.name, i, INST_CODE, e.inst);
      end
      checks++;
      if (ADDR_ERR !== e.err) begin
        failures++;
        $display("FAIL %s[%0d] err got %b want %b", e.name, i, ADDR_ERR, e.err);
      end
    end
  endtask

  task automatic test_program();
    exp_t e;
    logic [31:0] pcs [6] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd252};
    foreach (pcs[i]) begin
      drive(pcs[i], 1'b0, "program");
      e = sb.pop_front();
      checks++;
      if (INST_CODE !== e.inst) begin
        failures++;
        $display("FAIL %s pc=%h inst got %h want %h", e.name, pcs[i], INST_CODE, e.inst);
      end
      checks++;
      if (ADDR_ERR !== e.err) begin
        failures++;
        $display("FAIL %s pc=%h err got %b want %b", e.name, pcs[i], ADDR_ERR, e.err);
      end
    end
  endtask

  task automatic test_addr_err();
    exp_t e;
    logic [31:0] pcs [7] = '{32'd2, 32'd256, 32'hFFFF_FFFC, 32'd4,
                             32'd257, 32'h0000_0103, 32'd255};
    foreach (pcs[i]) begin
      drive(pcs[i], 1'b0, "addr_err");
      e = sb.pop_front();
      checks++;
      if (INST_CODE !== e.inst) begin
        failures++;
        $display("FAIL %s pc=%h inst got %h want %h", e.name, pcs[i], INST_CODE, e.inst);
      end
      checks++;
      if (ADDR_ERR !== e.err) begin
        failures++;
        $display("FAIL %s pc=%h err got %b want %b", e.name, pcs[i], ADDR_ERR, e.err);
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    logic [31:0] pcs [3] = '{32'd8, 32'd12, 32'd12};
    logic        rst [3] = '{1'b0, 1'b1, 1'b0};
    foreach (pcs[i]) begin
      drive(pcs[i], rst[i], "mid_reset");
      e = sb.pop_front();
      checks++;
      if (INST_CODE !== e.inst) begin
        failures++;
        $display("FAIL %s[%0d] inst got %h want %h", e.name, i, INST_CODE, e.inst);
      end
      checks++;
      if (ADDR_ERR !== e.err) begin
        failures++;
        $display("FAIL %s[%0d] err got %b want %b", e.name, i, ADDR_ERR, e.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] pc;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       pc = {24'd0, 4'($urandom_range(0, 15)), 2'b00, 2'b00} >> 2;
        1:       pc = {24'd0, 8'($urandom_range(0, 255))};
        2:       pc = 32'd256 + 32'($urandom_range(0, 4096));
        default: pc = $urandom;
      endcase
      drive(pc, 1'b0, "b2b");
      e = sb.pop_front();
      checks++;
      if (INST_CODE !== e.inst) begin
        failures++;
        $display("FAIL %s pc=%h inst got %h want %h", e.name, pc, INST_CODE, e.inst);
      end
      checks++;
      if (ADDR_ERR !== e.err) begin
        failures++;
        $display("FAIL %s pc=%h err got %b want %b", e.name, pc, ADDR_ERR, e.err);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left %0d want 0", sb.size());
    end
  endtask

  initial begin
    CLK   = 1'b0;
    RESET = 1'b1;
    PC    = 32'd0;
    @(negedge CLK);
    test_reset();
    test_program();
    test_addr_err();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit words (byte capacity = 4*DEPTH_WORDS = 256).
REQ-002 Parameter NOP_WORD, default 32'h0000_0013, RV32I "addi x0,x0,0" returned for invalid fetches and on reset.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset; sampled on rising CLK.
REQ-005 PC  input  32  byte address of the instruction to fetch.
REQ-006 INST_CODE  output  32  registered fetched instruction word.
REQ-007 ADDR_ERR  output  1  registered flag; 1 when the fetch at the sampled PC was invalid.

Function
REQ-008 Storage SHALL be a byte-addressable array of 4*DEPTH_WORDS bytes; read-only, with no write port.
REQ-009 Word assembly SHALL be little-endian: INST_CODE = {mem[PC+3], mem[PC+2], mem[PC+1], mem[PC]}.
REQ-010 Read latency SHALL be one cycle: PC sampled at edge N yields INST_CODE/ADDR_ERR valid after edge N; no handshake, a new PC is accepted every cycle.
REQ-011 Valid fetch: PC[1:0]==0 and PC < 4*DEPTH_WORDS -> INST_CODE = stored word, ADDR_ERR = 0.
REQ-012 Misaligned fetch (PC[1:0]!=0) SHALL yield INST_CODE = NOP_WORD, ADDR_ERR = 1.
REQ-013 Out-of-range fetch (PC >= 4*DEPTH_WORDS, all 32 bits compared, no wrap-around) SHALL yield INST_CODE = NOP_WORD, ADDR_ERR = 1.
REQ-014 Misaligned and out-of-range together SHALL behave as REQ-012/013 (single ADDR_ERR=1).
REQ-015 PC containing X/Z is not defined behaviour; the implementation need not handle it.
REQ-016 Program image, loaded into the array on reset:
  word0 (byte 0) = 32'h002081B3 (add x3,x1,x2)
  word1 (byte 4) = 32'h40118233 (sub x4,x3,x1)
  word2 (byte 8) = 32'h002272B3 (and x5,x4,x2)
  word3 (byte 12) = 32'h0032E333 (or x6,x5,x3)
  all remaining words = NOP_WORD.
REQ-017 Outputs SHALL hold their last value between edges; the array SHALL be unchanged by fetches.

Reset
REQ-018 On a rising CLK with RESET=1: array reloaded with the REQ-016 image, INST_CODE <= NOP_WORD, ADDR_ERR <= 0.
REQ-019 While RESET stays 1, outputs SHALL remain NOP_WORD/0 regardless of PC.
REQ-020 The first fetch SHALL occur on the first rising edge with RESET=0; the result is visible after that edge.
REQ-021 Reset asserted mid-stream SHALL take priority over a fetch on the same edge.
REQ-022 Before the first reset, array and output contents are undefined.

Structure
REQ-023 Shared package instr_mem_pkg SHALL hold NOP_WORD, default DEPTH_WORDS, and the program-image constants/function (word index -> 32-bit word).
REQ-024 The design SHALL be a single module with no sub-modules; the address checks and byte assembly are combinational logic feeding one output register stage.

Verification
REQ-025 RESET=1 for 2 edges, PC=0 -> INST_CODE=32'h00000013, ADDR_ERR=0 throughout.
REQ-026 Release reset, PC=0,4,8,12 on successive edges -> one cycle later INST_CODE=002081B3, 40118233, 002272B3, 0032E333, ADDR_ERR=0.
REQ-027 PC=16 and PC=252 -> INST_CODE=00000013, ADDR_ERR=0.
REQ-028 PC=2, then PC=256, then PC=32'hFFFF_FFFC -> INST_CODE=00000013, ADDR_ERR=1 for each; next PC=4 -> 40118233, ADDR_ERR=0.
REQ-029 Stream PC=8, assert RESET on the following edge with PC=12 -> INST_CODE=002272B3 then 00000013; after release, PC=12 -> 0032E333.
